regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, width of each register entry in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port REG_rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-007 Port REG_rd_data  output  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
REQ-008 Port REG_wr_en  input  2  write enables for write ports 0 and 1.
REQ-009 Port REG_wr_addr  input  2*ADDR_W  packed write addresses.
REQ-010 Port REG_wr_data  input  2*DATA_W  packed write data.
REQ-011 Port REG_busy  output  1  high while the clear sweep runs; writes are ignored.
REQ-012 Port REG_dbg_addr  input  ADDR_W  debug read address.
REQ-013 Port REG_dbg_data  output  DATA_W  debug read data, array contents only, never bypassed.

Function
REQ-014 Reads SHALL be combinational from the array; every read port is independent.
REQ-015 Entry 0 SHALL read as zero on all ports; writes to address 0 SHALL be discarded.
REQ-016 A write with REG_wr_en[w]=1, address nonzero and REG_busy=0 SHALL update the entry at the next rising edge.
REQ-017 Both write ports to the same nonzero address in one cycle: port 1 SHALL win and port 0 SHALL be dropped.
REQ-018 FSM states SHALL be CLEAR and READY; CLEAR holds REG_busy=1; READY holds REG_busy=0.
REQ-019 In CLEAR, a sweep counter SHALL zero entry cnt each cycle and increment; after entry DEPTH-1 is zeroed the FSM SHALL enter READY.
REQ-020 REG_busy SHALL fall exactly DEPTH rising edges after the edge on which rst was sampled low.
REQ-021 While REG_busy=1, all REG_rd_data and REG_dbg_data SHALL read zero, and write requests SHALL be silently dropped.
REQ-022 The sweep counter SHALL be ADDR_W bits wide and SHALL NOT wrap back into CLEAR once READY is reached.

Reset
REQ-023 rst high at a rising edge SHALL force state CLEAR and counter 0, and SHALL drop any write sampled in that cycle.
REQ-024 During and immediately after reset, REG_busy=1 and all read outputs SHALL be 0.
REQ-025 rst asserted mid-sweep or in READY SHALL restart the sweep from entry 0.

Configuration
REQ-026 With REGFILE_BYPASS_EN defined, a read whose address matches an enabled same-cycle write (nonzero address, REG_busy=0) SHALL return the write data, with port 1 data taking priority over port 0.
REQ-027 Without REGFILE_BYPASS_EN, reads SHALL return pre-edge array contents; new data SHALL be visible only after the write edge.

Structure
REQ-028 Shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, READY) and default constants (DATA_W, ADDR_W, NUM_RD).
REQ-029 Per-port read plus bypass logic SHALL be a sub-module regfile_rd_port, instantiated NUM_RD times by a generate loop.

Verification
REQ-030 Reset release: rst 1->0; REG_busy=1 for 32 edges, then 0; a read of addr 7 returns 0x00000000 throughout the sweep and after it.
REQ-031 Write/read: wr0 addr 5 data 0xDEADBEEF; next cycle rd port 1 addr 5 -> 0xDEADBEEF; dbg addr 5 -> 0xDEADBEEF.
REQ-032 Collision: wr0 and wr1 both addr 9, data 0x11111111 and 0x22222222 -> entry 9 = 0x22222222.
REQ-033 Zero register: write 0xFFFFFFFF to addr 0 -> all ports read addr 0 as 0.
REQ-034 Bypass: same-cycle wr1 addr 3 0xCAFEF00D with rd addr 3 -> 0xCAFEF00D if REGFILE_BYPASS_EN is defined, otherwise the old value until the next edge.
REQ-035 Mid-sweep reset: rst pulsed at sweep count 10 -> REG_busy stays 1 for 32 edges after release; a write during busy to addr 4 is lost (reads 0).

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Purpose : Shared definitions for the multi-port register file. Holds the
//           clear-sweep FSM state type and the default geometry constants
//           used as parameter defaults by regfile_mp and regfile_rd_port.
// Ports   : none (package)
// Config  : REGFILE_BYPASS_EN (used by regfile_mp / regfile_rd_port)
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // CLEAR: sweep is zeroing the array, the file is busy.
    // READY: normal read/write operation.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// ----------------------------------------------------------------------------
// regfile_rd_port
// Purpose : One combinational read port of the register file. Forces zero
//           for entry 0 and while the clear sweep runs. With
//           REGFILE_BYPASS_EN defined it forwards same-cycle write data,
//           write port 1 taking priority over write port 0.
// Ports   : addr       - read address
//           array_data - array word already selected by addr
//           busy       - clear sweep in progress
//           wr_en      - write enables (bypass build only)
//           wr_addr    - packed write addresses (bypass build only)
//           wr_data    - packed write data (bypass build only)
//           data       - read result
// Config  : REGFILE_BYPASS_EN enables write-to-read forwarding.
// ----------------------------------------------------------------------------
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   array_data,
    input  logic                busy,
`ifdef REGFILE_BYPASS_EN
    input  logic [1:0]          wr_en,
    input  logic [2*ADDR_W-1:0] wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0]   data
);

    // Zero entry and busy masking come first. Since addr is nonzero past
    // that point, a matching write address is implicitly nonzero too, so
    // the bypass only ever forwards writes the array would really accept.
    always_comb begin
        data = array_data;
        if (busy || addr == '0) begin
            data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en[1] && wr_addr[ADDR_W +: ADDR_W] == addr) begin
            data = wr_data[DATA_W +: DATA_W];
        end
        else if (wr_en[0] && wr_addr[0 +: ADDR_W] == addr) begin
            data = wr_data[0 +: DATA_W];
        end
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Purpose : Register file with NUM_RD combinational read ports, two write
//           ports, a debug read port and a post-reset clear sweep. Entry 0
//           is hardwired to zero. After reset a sweep zeroes one entry per
//           cycle; REG_busy is high during the sweep and all reads return
//           zero while writes are dropped.
// Ports   : clk          - clock, all state on rising edge
//           rst          - synchronous active-high reset
//           REG_rd_addr  - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//           REG_rd_data  - packed read data, port k at [k*DATA_W +: DATA_W]
//           REG_wr_en    - write enables for write ports 0 and 1
//           REG_wr_addr  - packed write addresses
//           REG_wr_data  - packed write data
//           REG_busy     - clear sweep in progress
//           REG_dbg_addr - debug read address
//           REG_dbg_data - debug read data, array contents only (no bypass)
// Config  : REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
// ----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   REG_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   REG_rd_data,
    input  logic [1:0]                 REG_wr_en,
    input  logic [2*ADDR_W-1:0]        REG_wr_addr,
    input  logic [2*DATA_W-1:0]        REG_wr_data,
    output logic                       REG_busy,
    input  logic [ADDR_W-1:0]          REG_dbg_addr,
    output logic [DATA_W-1:0]          REG_dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] cnt;

    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic              wr_ok0;
    logic              wr_ok1;

    assign wr_addr0 = REG_wr_addr[0 +: ADDR_W];
    assign wr_addr1 = REG_wr_addr[ADDR_W +: ADDR_W];
    assign wr_data0 = REG_wr_data[0 +: DATA_W];
    assign wr_data1 = REG_wr_data[DATA_W +: DATA_W];
    assign wr_ok0   = REG_wr_en[0] && (wr_addr0 != '0);
    assign wr_ok1   = REG_wr_en[1] && (wr_addr1 != '0);

    // Clear-sweep FSM. Reset parks it in CLEAR at entry 0; each edge in
    // CLEAR advances the counter, and the edge that zeroes the last entry
    // moves to READY. The counter wraps to 0 on that edge but nothing
    // looks at it in READY, so the sweep never restarts without a reset.
    // REG_busy is registered alongside the state so it stays glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            REG_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= READY;
                        REG_busy <= 1'b0;
                    end
                end
                READY: begin
                    state    <= READY;
                    REG_busy <= 1'b0;
                end
                default: begin
                    state    <= CLEAR;
                    cnt      <= '0;
                    REG_busy <= 1'b1;
                end
            endcase
        end
    end

    // Array update. The sweep owns the array while in CLEAR, so user
    // writes are only honoured in READY and never on a reset edge. Port 1
    // is written after port 0 so it wins when both target the same entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wr_ok0) begin
                    mem[wr_addr0] <= wr_data0;
                end
                if (wr_ok1) begin
                    mem[wr_addr1] <= wr_data1;
                end
            end
        end
    end

    // One read-port instance per requested port; each does its own
    // zero/busy masking and optional forwarding.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .addr       (REG_rd_addr[k*ADDR_W +: ADDR_W]),
            .array_data (mem[REG_rd_addr[k*ADDR_W +: ADDR_W]]),
            .busy       (REG_busy),
`ifdef REGFILE_BYPASS_EN
            .wr_en      (REG_wr_en),
            .wr_addr    (REG_wr_addr),
            .wr_data    (REG_wr_data),
`endif
            .data       (REG_rd_data[k*DATA_W +: DATA_W])
        );
    end

    // Debug port shows raw array contents and is never forwarded, which
    // makes it a reliable view of what has actually been committed.
    always_comb begin
        REG_dbg_data = mem[REG_dbg_addr];
        if (REG_busy || REG_dbg_addr == '0) begin
            REG_dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// Purpose : Self-checking bench for regfile_mp with default parameters.
//           A behavioural model (plain array plus remaining-busy-cycle
//           count) predicts every output each cycle; directed vectors add
//           hand-computed literal expectations.
// Config  : honours REGFILE_BYPASS_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     clk;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [1:0]               wr_en;
    logic [2*ADDR_W-1:0]      wr_addr;
    logic [2*DATA_W-1:0]      wr_data;
    logic                     busy;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    int vec_count;
    int miss_count;
    logic checking;

    logic [DATA_W-1:0] model_mem [DEPTH];
    int                model_left;

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .REG_rd_addr  (rd_addr),
        .REG_rd_data  (rd_data),
        .REG_wr_en    (wr_en),
        .REG_wr_addr  (wr_addr),
        .REG_wr_data  (wr_data),
        .REG_busy     (busy),
        .REG_dbg_addr (dbg_addr),
        .REG_dbg_data (dbg_data)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value, count it, and report a miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle worth of inputs shortly after the rising edge, then
    // wait for the falling edge where outputs are settled.
    task automatic applyStimulus(input logic r, input logic [1:0] en,
                                 input logic [4:0] a0, input logic [31:0] d0,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [4:0] r0, input logic [4:0] r1,
                                 input logic [4:0] dbg);
        @(posedge clk);
        #2;
        rst      = r;
        wr_en    = en;
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        rd_addr  = {r1, r0};
        dbg_addr = dbg;
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] dbg);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, r0, r1, dbg);
    endtask

    // Behavioural model of committed state. A reset edge empties the whole
    // file at once and arms a DEPTH-cycle busy window; since everything
    // reads zero while busy, the gradual sweep is invisible from outside.
    // Once idle, accepted writes land in order port 0 then port 1.
    always @(posedge clk) begin
        if (rst) begin
            model_left = DEPTH;
            foreach (model_mem[i]) model_mem[i] = '0;
        end else if (model_left > 0) begin
            model_left = model_left - 1;
        end else begin
            if (wr_en[0] && wr_addr[4:0] != 5'd0) model_mem[wr_addr[4:0]] = wr_data[31:0];
            if (wr_en[1] && wr_addr[9:5] != 5'd0) model_mem[wr_addr[9:5]] = wr_data[63:32];
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (model_left > 0 || a == 5'd0) return 32'h0;
        if (BYPASS) begin
            if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
            if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
        end
        return model_mem[a];
    endfunction

    // Every falling edge, check all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_busy", {31'b0, busy}, 32'(model_left > 0));
            for (int k = 0; k < NUM_RD; k++) begin
                checkOutput($sformatf("model_rd%0d", k), rd_data[k*DATA_W +: DATA_W],
                            model_read(rd_addr[k*ADDR_W +: ADDR_W]));
            end
            checkOutput("model_dbg", dbg_data,
                        (model_left > 0) ? 32'h0 : model_mem[dbg_addr]);
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        vec_count  = 0;
        miss_count = 0;
        checking   = 1'b0;
        model_left = DEPTH;
        foreach (model_mem[i]) model_mem[i] = '0;
        rst      = 1'b1;
        wr_en    = 2'b00;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = {5'd7, 5'd7};
        dbg_addr = 5'd7;

        $display("[TB] reset and first sweep");
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        checking = 1'b1;
        checkOutput("reset_busy", {31'b0, busy}, 32'h1);
        checkOutput("reset_rd0", rd_data[31:0], 32'h0);
        checkOutput("reset_dbg", dbg_data, 32'h0);
        idle(5'd7, 5'd7, 5'd7);
        checkOutput("release_busy", {31'b0, busy}, 32'h1);
        for (int i = 1; i <= 32; i++) begin
            idle(5'd7, 5'd7, 5'd7);
            checkOutput("sweep_busy", {31'b0, busy}, 32'(i < 32));
            checkOutput("sweep_rd7", rd_data[31:0], 32'h0);
        end

        $display("[TB] write then read");
        applyStimulus(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd5, 5'd5);
        checkOutput("wr5_same_rd1", rd_data[63:32], BYPASS ? 32'hDEADBEEF : 32'h0);
        checkOutput("wr5_same_dbg", dbg_data, 32'h0);
        idle(5'd0, 5'd5, 5'd5);
        checkOutput("wr5_rd1", rd_data[63:32], 32'hDEADBEEF);
        checkOutput("wr5_dbg", dbg_data, 32'hDEADBEEF);

        $display("[TB] write collision");
        applyStimulus(1'b0, 2'b11, 5'd9, 32'h11111111, 5'd9, 32'h22222222, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9, 5'd9);
        checkOutput("coll_rd0", rd_data[31:0], 32'h22222222);
        checkOutput("coll_dbg", dbg_data, 32'h22222222);

        $display("[TB] zero register");
        applyStimulus(1'b0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        checkOutput("zero_same_rd0", rd_data[31:0], 32'h0);
        checkOutput("zero_same_rd1", rd_data[63:32], 32'h0);
        idle(5'd0, 5'd0, 5'd0);
        checkOutput("zero_rd0", rd_data[31:0], 32'h0);
        checkOutput("zero_rd1", rd_data[63:32], 32'h0);
        checkOutput("zero_dbg", dbg_data, 32'h0);

        $display("[TB] bypass behaviour");
        applyStimulus(1'b0, 2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        applyStimulus(1'b0, 2'b10, 5'd0, 32'h0, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 5'd3);
        checkOutput("byp_rd0", rd_data[31:0], BYPASS ? 32'hCAFEF00D : 32'h12345678);
        checkOutput("byp_dbg", dbg_data, 32'h12345678);
        idle(5'd3, 5'd3, 5'd3);
        checkOutput("byp_after_rd0", rd_data[31:0], 32'hCAFEF00D);
        applyStimulus(1'b0, 2'b11, 5'd6, 32'hAAAAAAAA, 5'd6, 32'hBBBBBBBB, 5'd6, 5'd3, 5'd6);
        checkOutput("byp_prio_rd0", rd_data[31:0], BYPASS ? 32'hBBBBBBBB : 32'h0);
        checkOutput("byp_prio_rd1", rd_data[63:32], 32'hCAFEF00D);
        idle(5'd6, 5'd6, 5'd6);
        checkOutput("prio_after_rd0", rd_data[31:0], 32'hBBBBBBBB);

        $display("[TB] directed write pattern");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 2'(i % 4),
                          5'((i * 7 + 1) % 32), 32'h10000000 + 32'(i) * 32'h01010101,
                          5'((i * 11 + 2) % 32), 32'h80000000 + 32'(i) * 32'h00100011,
                          5'((i * 7 + 1) % 32), 5'(((i + 31) * 11 + 2) % 32),
                          5'((i * 3) % 32));
        end
        for (int i = 0; i < 8; i++) begin
            idle(5'(i * 4 + 1), 5'(i * 4 + 2), 5'(i * 4 + 3));
        end

        $display("[TB] mid-sweep reset");
        applyStimulus(1'b0, 2'b01, 5'd12, 32'h0C0C0C0C, 5'd0, 32'h0, 5'd12, 5'd0, 5'd12);
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd12);
        checkOutput("pre_rst_dbg12", dbg_data, 32'h0C0C0C0C);
        idle(5'd12, 5'd0, 5'd12);
        checkOutput("rst1_busy", {31'b0, busy}, 32'h1);
        for (int i = 1; i <= 9; i++) begin
            idle(5'd12, 5'd0, 5'd12);
        end
        applyStimulus(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd12, 5'd5);
        idle(5'd4, 5'd12, 5'd5);
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin
                applyStimulus(1'b0, 2'b01, 5'd4, 32'h44444444, 5'd0, 32'h0, 5'd4, 5'd12, 5'd5);
            end else begin
                idle(5'd4, 5'd12, 5'd5);
            end
            checkOutput("resweep_busy", {31'b0, busy}, 32'(i < 32));
        end
        idle(5'd4, 5'd12, 5'd5);
        checkOutput("lost_wr4", rd_data[31:0], 32'h0);
        checkOutput("cleared12", rd_data[63:32], 32'h0);
        checkOutput("cleared5_dbg", dbg_data, 32'h0);
        applyStimulus(1'b0, 2'b01, 5'd4, 32'h44444444, 5'd0, 32'h0, 5'd4, 5'd9, 5'd4);
        idle(5'd4, 5'd9, 5'd4);
        checkOutput("post_wr4", rd_data[31:0], 32'h44444444);
        checkOutput("cleared9", rd_data[63:32], 32'h0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
